decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 2: select width; legal range 1..5.
REQ-002 Parameter OUT_W, default 2**SEL_W: output count; derived from SEL_W, never overridden.
REQ-003 Parameter PRESCALE, default 4: clock cycles per scan step; legal range 2..65535.
REQ-004 Parameter BLANK, default 1: blanked cycles at the start of each scan step; legal range 0..PRESCALE-1.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port en_n, input, 1: enable, active-low; 0 = decoder active, 1 = all outputs inactive.
REQ-008 Port mode, input, 1: 0 = DIRECT (decode sel), 1 = SCAN (auto-cycle outputs).
REQ-009 Port sel, input, SEL_W: line to drive low in DIRECT mode.
REQ-010 Port y_n, output, OUT_W: one-hot-low decoded outputs, registered.
REQ-011 Port idx, output, SEL_W: index currently or most recently decoded, registered.
REQ-012 Port wrap, output, 1: one-cycle pulse when a SCAN sequence wraps from OUT_W-1 to 0.

Function
REQ-013 y_n SHALL be all ones or have exactly one bit at 0; it never has two or more bits at 0.
REQ-014 y_n, idx and wrap SHALL be driven directly from flops, with no combinational path from any input.
REQ-015 DIRECT (en_n=0, mode=0) SHALL load y_n with bit sel at 0 and all other bits at 1, and idx=sel, one edge after sel is sampled (latency 1); the prescale count is held at 0.
REQ-016 SCAN (en_n=0, mode=1) SHALL advance the prescale count 0..PRESCALE-1 each cycle; when it is PRESCALE-1, the next edge loads count 0 and idx=(idx+1) mod OUT_W.
REQ-017 In SCAN, y_n SHALL be all ones while the registered count < BLANK; otherwise y_n has bit idx at 0.
REQ-018 wrap SHALL be 1 for exactly the one cycle in which idx has just changed from OUT_W-1 to 0 in SCAN; it is 0 otherwise.
REQ-019 Disabled (en_n=1) SHALL set y_n to all ones on the next edge, hold idx and the prescale count, and force wrap to 0; when en_n returns to 0, operation resumes from the held state.
REQ-020 A DIRECT-to-SCAN switch SHALL clear the prescale count to 0 and start scanning from the current idx, with no step skipped.
REQ-021 A SCAN-to-DIRECT switch SHALL show the decoded sel on the next edge, abandoning the step in progress; no wrap pulse is produced.
REQ-022 idx arithmetic SHALL be modulo OUT_W; when OUT_W=2**SEL_W, natural overflow is the wrap.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock, force y_n all ones, idx=0, wrap=0 and prescale count 0.
REQ-024 Reset release SHALL be synchronised so that the first state change occurs no earlier than the second rising clk edge after rst_n rises.
REQ-025 Reset asserted mid-step or mid-wrap SHALL abandon the step; after release, scanning restarts at idx=0, count 0.

Structure
REQ-026 Package decoder_pkg SHALL hold the MODE_DIRECT/MODE_SCAN constants and a one-hot-low decode function of (index, width).
REQ-027 The prescale counter with its terminal-count and clear logic SHALL be a sub-module named scan_prescaler, parametrised by PRESCALE.
REQ-028 Parameter legality (REQ-001, REQ-003, REQ-004) SHALL be checked at elaboration, with a fatal error on violation.

Verification (SEL_W=2, PRESCALE=4, BLANK=1)
REQ-029 Reset, then en_n=0, mode=0, sel=2 -> y_n=4'b1011, idx=2 one edge later; sel=3 -> y_n=4'b0111.
REQ-030 mode=1 held for 16 cycles from idx=0 -> per 4-cycle step y_n is 1111 for 1 cycle then low on idx 0,1,2,3 for 3 cycles; wrap pulses once when idx returns to 0.
REQ-031 en_n=1 for 5 cycles mid-step at idx=1, count 2 -> y_n=1111, idx=1 held; after en_n=0, idx=1 persists for the remaining 1 cycle, then steps to 2.
REQ-032 SCAN at idx=3, then mode=0 with sel=0 -> next edge y_n=4'b1110 and wrap stays 0.
REQ-033 rst_n pulsed low between edges during SCAN -> y_n=1111 and idx=0 immediately; after release scanning restarts at idx 0.
REQ-034 Random en_n/mode/sel for 10^4 cycles -> onehot-low invariant (REQ-013) holds and the wrap count equals the number of completed sequences.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared mode encodings and the one-hot-low decode helper for the scan decoder.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  localparam int   MAX_OUT_W   = 32;

  // All ones except bit 'index' at 0; an out-of-range index yields all ones.
  function automatic logic [MAX_OUT_W-1:0] onehot_low(input int unsigned index,
                                                      input int unsigned width);
    logic [MAX_OUT_W-1:0] r;
    r = '1;
    if (index < width && index < MAX_OUT_W) r[index[4:0]] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan step prescaler: counts 0..PRESCALE-1 while advancing, with clear and terminal count.
module scan_prescaler #(
  parameter int PRESCALE = 4,
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  // cnt_nxt is exported so the owner can register outputs that depend on the new count.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)      cnt_nxt = '0;
    else if (adv) cnt_nxt = tc ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (run) cnt <= cnt_nxt;
  end

endmodule

// File: rtl/decoder_scan.sv
// One-hot-low decoder with direct select and auto-scan modes; all outputs come from flops.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int OUT_W    = 2**SEL_W,
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y_n,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  if (SEL_W < 1 || SEL_W > 5) begin : g_bad_sel_w
    $fatal(1, "decoder_scan: SEL_W=%0d outside 1..5", SEL_W);
  end
  if (OUT_W != 2**SEL_W) begin : g_bad_out_w
    $fatal(1, "decoder_scan: OUT_W must equal 2**SEL_W");
  end
  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $fatal(1, "decoder_scan: PRESCALE=%0d outside 2..65535", PRESCALE);
  end
  if (BLANK < 0 || BLANK > PRESCALE - 1) begin : g_bad_blank
    $fatal(1, "decoder_scan: BLANK=%0d outside 0..PRESCALE-1", BLANK);
  end

  localparam int                CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]  BLANK_C  = CNT_W'(BLANK);
  localparam logic [SEL_W-1:0]  IDX_LAST = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0]  ALL_OFF  = '1;

  logic [1:0]       rst_sync;
  logic             run;
  logic             clr;
  logic             adv;
  logic             tc;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic [OUT_W-1:0] dec_sel;
  logic [OUT_W-1:0] dec_idx;

  // Release is synchronised: state may only move once the release has crossed two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign clr     = !en_n && (mode == MODE_DIRECT);
  assign adv     = !en_n && (mode == MODE_SCAN);
  assign idx_nxt = tc ? idx + SEL_W'(1) : idx;
  assign dec_sel = OUT_W'(onehot_low(32'(sel), OUT_W));
  assign dec_idx = OUT_W'(onehot_low(32'(idx_nxt), OUT_W));

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .clr     (clr),
    .adv     (adv),
    .cnt_nxt (cnt_nxt),
    .tc      (tc)
  );

  // y_n is computed from the next count/index so the registered value matches the registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_n  <= ALL_OFF;
      idx  <= '0;
      wrap <= 1'b0;
    end else if (run) begin
      if (en_n) begin
        y_n  <= ALL_OFF;
        wrap <= 1'b0;
      end else if (mode == MODE_DIRECT) begin
        y_n  <= dec_sel;
        idx  <= sel;
        wrap <= 1'b0;
      end else begin
        idx  <= idx_nxt;
        wrap <= tc && (idx == IDX_LAST);
        y_n  <= (cnt_nxt < BLANK_C) ? ALL_OFF : dec_idx;
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: directed vector table, reset corner sequences, and a random run against a reference model.
module tb_decoder_scan;

  localparam int SEL_W    = 2;
  localparam int OUT_W    = 4;
  localparam int PRESCALE = 4;
  localparam int BLANK    = 1;
  localparam int ONES     = (1 << OUT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en_n;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] y_n;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  int n_chk  = 0;
  int n_fail = 0;
  int dut_wraps = 0;
  bit mdl_on = 0;

  decoder_scan #(.SEL_W(SEL_W), .PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en_n  (en_n),
    .mode  (mode),
    .sel   (sel),
    .y_n   (y_n),
    .idx   (idx),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: step index/count with plain integer arithmetic.
  typedef struct packed {
    int idx;
    int cnt;
    int y;
    int wrap;
    int seqs;
  } mst_t;

  mst_t m;

  function automatic mst_t model_next(mst_t s, logic e, logic md, logic [SEL_W-1:0] sl);
    mst_t n;
    n = s;
    n.wrap = 0;
    if (e) begin
      n.y = ONES;
    end else if (md == 1'b0) begin
      n.idx = int'(sl);
      n.cnt = 0;
      n.y   = ONES & ~(1 << int'(sl));
    end else begin
      n.cnt = s.cnt + 1;
      if (n.cnt == PRESCALE) begin
        n.cnt = 0;
        n.idx = (s.idx + 1) % OUT_W;
        if (n.idx == 0) begin
          n.wrap = 1;
          n.seqs = s.seqs + 1;
        end
      end
      n.y = (n.cnt < BLANK) ? ONES : (ONES & ~(1 << n.idx));
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{idx: 0, cnt: 0, y: ONES, wrap: 0, seqs: m.seqs};
    else        m <= model_next(m, en_n, mode, sel);
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("mdl_y_n", 32'(y_n), m.y);
      chk("mdl_idx", 32'(idx), m.idx);
      chk("mdl_wrap", 32'(wrap), m.wrap);
      chk("onehot_low", 32'($countones(~y_n) <= 1), 32'd1);
      if (wrap === 1'b1) dut_wraps++;
    end
  end

  typedef struct packed {
    logic             en_n;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic md, input logic [SEL_W-1:0] s,
                     input logic [OUT_W-1:0] y, input logic [SEL_W-1:0] ix,
                     input logic w, input int n);
    vec_t v;
    v.en_n = e; v.mode = md; v.sel = s; v.y = y; v.idx = ix; v.wrap = w;
    repeat (n) tbl.push_back(v);
  endtask

  initial begin
    int k;
    int s0;
    int w0;

    // Scan from idx 0 count 0: 16 cycles with one wrap, then disable mid-step, resume, and switch modes.
    add(0, 0, 0, 4'b1110, 0, 0, 1);
    add(0, 1, 0, 4'b1110, 0, 0, 3);
    add(0, 1, 0, 4'b1111, 1, 0, 1);
    add(0, 1, 0, 4'b1101, 1, 0, 3);
    add(0, 1, 0, 4'b1111, 2, 0, 1);
    add(0, 1, 0, 4'b1011, 2, 0, 3);
    add(0, 1, 0, 4'b1111, 3, 0, 1);
    add(0, 1, 0, 4'b0111, 3, 0, 3);
    add(0, 1, 0, 4'b1111, 0, 1, 1);
    add(0, 1, 0, 4'b1110, 0, 0, 3);
    add(0, 1, 0, 4'b1111, 1, 0, 1);
    add(0, 1, 0, 4'b1101, 1, 0, 2);
    add(1, 1, 0, 4'b1111, 1, 0, 5);
    add(0, 1, 0, 4'b1101, 1, 0, 1);
    add(0, 1, 0, 4'b1111, 2, 0, 1);
    add(0, 1, 0, 4'b1011, 2, 0, 3);
    add(0, 1, 0, 4'b1111, 3, 0, 1);
    add(0, 1, 0, 4'b0111, 3, 0, 1);
    add(0, 0, 0, 4'b1110, 0, 0, 1);
    add(0, 1, 1, 4'b1110, 0, 0, 2);

    rst_n = 1'b1; en_n = 1'b1; mode = 1'b0; sel = '0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_y_n", 32'(y_n), 32'hF);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; en_n = 1'b0; mode = 1'b0; sel = 2'd2;
    @(negedge clk);
    chk("rst_release_hold_y_n", 32'(y_n), 32'hF);
    chk("rst_release_hold_idx", 32'(idx), 32'd0);
    k = 0;
    while (idx !== 2'd2 && k < 5) begin
      @(negedge clk);
      k++;
    end
    chk("direct_sel2_y_n", 32'(y_n), 32'hB);
    chk("direct_sel2_idx", 32'(idx), 32'd2);

    sel = 2'd3;
    @(negedge clk);
    chk("direct_sel3_y_n", 32'(y_n), 32'h7);
    chk("direct_sel3_idx", 32'(idx), 32'd3);
    chk("direct_sel3_wrap", 32'(wrap), 32'd0);
    mdl_on = 1;

    foreach (tbl[i]) begin
      en_n = tbl[i].en_n; mode = tbl[i].mode; sel = tbl[i].sel;
      @(negedge clk);
      chk($sformatf("vec%0d_y_n", i), 32'(y_n), 32'(tbl[i].y));
      chk($sformatf("vec%0d_idx", i), 32'(idx), 32'(tbl[i].idx));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tbl[i].wrap));
    end

    // Asynchronous reset pulse between edges while scanning mid-step.
    en_n = 1'b0; mode = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y_n", 32'(y_n), 32'hF);
    chk("async_rst_idx", 32'(idx), 32'd0);
    chk("async_rst_wrap", 32'(wrap), 32'd0);
    #1 rst_n = 1'b1; en_n = 1'b1;
    repeat (3) @(negedge clk);
    en_n = 1'b0;
    @(negedge clk);
    chk("rst_restart_y_n", 32'(y_n), 32'hE);
    chk("rst_restart_idx", 32'(idx), 32'd0);

    s0 = m.seqs;
    w0 = dut_wraps;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(39) == 0) mode = ~mode;
      en_n = ($urandom_range(9) == 0);
      sel  = 2'($urandom_range(3));
      @(negedge clk);
    end
    chk("wrap_count", 32'(dut_wraps - w0), 32'(m.seqs - s0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
